// File: rtl/sprite_pkg.sv
// Shared types and field positions for the sprite motion controller.
package sprite_pkg;

    typedef logic signed [10:0] coord_t;

    typedef enum logic [1:0] {
        OP_SET_VEL = 2'd0,
        OP_SET_POS = 2'd1,
        OP_PAUSE   = 2'd2,
        OP_RESUME  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        CALC   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam int unsigned COORD_W = 11;

    // pixel_pos = {right, left, bottom, top}
    localparam int unsigned POS_TOP_LSB    = 0;
    localparam int unsigned POS_BOTTOM_LSB = 11;
    localparam int unsigned POS_LEFT_LSB   = 22;
    localparam int unsigned POS_RIGHT_LSB  = 33;

    // cmd_data = {row_val, col_val}
    localparam int unsigned CMD_COL_LSB = 0;
    localparam int unsigned CMD_ROW_LSB = 11;

    function automatic coord_t clamp_coord(coord_t v, coord_t lo, coord_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Command port of the sprite motion controller: valid/ready with opcode and packed data.
interface sprite_motion_ctrl_if;
    import sprite_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    cmd_op_t     cmd_op;
    logic [21:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/sprite_motion_ctrl_axis_step.sv
// One-axis motion step: advance by velocity, or pin to the edge and reflect velocity.
module axis_step
    import sprite_pkg::*;
(
    input  coord_t lo,
    input  coord_t hi,
    input  coord_t vel,
    input  coord_t offset,
    input  coord_t limit,
    input  coord_t base,
    output coord_t next_offset,
    output coord_t next_vel,
    output logic   bounce
);

    logic signed [11:0] cand_lo;
    logic signed [11:0] cand_hi;
    logic signed [11:0] limit_ext;

    always_comb begin
        cand_lo   = {lo[10], lo} + {vel[10], vel};
        cand_hi   = {hi[10], hi} + {vel[10], vel};
        limit_ext = {limit[10], limit};
        next_offset = offset + vel;
        next_vel    = vel;
        bounce      = 1'b0;
        if (vel != '0) begin
            if (cand_lo < 12'sd0) begin
                next_offset = -base;
                next_vel    = -vel;
                bounce      = 1'b1;
            end else if (cand_hi >= limit_ext) begin
                next_offset = limit - coord_t'(2) - base;
                next_vel    = -vel;
                bounce      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position sequencer: moves and bounces the sprite once per frame tick.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int V_VISIBLE   = 480,
    parameter int H_VISIBLE   = 640,
    parameter int SPRITE_ROW0 = 100,
    parameter int SPRITE_COL0 = 100,
    parameter int MAX_SPEED   = 7
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 frame_tick,
    sprite_motion_ctrl_if.slave  cmd,
    input  logic [43:0]          pixel_pos,
    output coord_t               row_offset,
    output coord_t               column_offset,
    output logic                 bounce_v,
    output logic                 bounce_h,
    output logic                 overrun
);

    localparam coord_t ROW_MIN  = coord_t'(-SPRITE_ROW0);
    localparam coord_t ROW_MAX  = coord_t'(V_VISIBLE - 2 - SPRITE_ROW0);
    localparam coord_t COL_MIN  = coord_t'(-SPRITE_COL0);
    localparam coord_t COL_MAX  = coord_t'(H_VISIBLE - 2 - SPRITE_COL0);
    localparam coord_t VEL_MIN  = coord_t'(-MAX_SPEED);
    localparam coord_t VEL_MAX  = coord_t'(MAX_SPEED);
    localparam coord_t V_LIM    = coord_t'(V_VISIBLE);
    localparam coord_t H_LIM    = coord_t'(H_VISIBLE);
    localparam coord_t ROW_BASE = coord_t'(SPRITE_ROW0);
    localparam coord_t COL_BASE = coord_t'(SPRITE_COL0);

    state_t state;
    logic   running;
    logic   paused;
    coord_t vel_r, vel_c;
    coord_t top_q, bottom_q, left_q, right_q;
    coord_t nxt_row, nxt_col, nxt_vr, nxt_vc;
    logic   nxt_bv, nxt_bh;
    coord_t calc_row, calc_col, calc_vr, calc_vc;
    logic   calc_bv, calc_bh;
    logic   cmd_fire;
    coord_t cmd_row, cmd_col;

    // running keeps ready low on the edges where reset is still held
    assign cmd.cmd_ready = running && (state == IDLE) && !frame_tick;
    assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd_row       = cmd.cmd_data[CMD_ROW_LSB +: COORD_W];
    assign cmd_col       = cmd.cmd_data[CMD_COL_LSB +: COORD_W];

    axis_step u_row_step (
        .lo          (top_q),
        .hi          (bottom_q),
        .vel         (vel_r),
        .offset      (row_offset),
        .limit       (V_LIM),
        .base        (ROW_BASE),
        .next_offset (nxt_row),
        .next_vel    (nxt_vr),
        .bounce      (nxt_bv)
    );

    axis_step u_col_step (
        .lo          (left_q),
        .hi          (right_q),
        .vel         (vel_c),
        .offset      (column_offset),
        .limit       (H_LIM),
        .base        (COL_BASE),
        .next_offset (nxt_col),
        .next_vel    (nxt_vc),
        .bounce      (nxt_bh)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state         <= IDLE;
            running       <= 1'b0;
            paused        <= 1'b0;
            row_offset    <= '0;
            column_offset <= '0;
            vel_r         <= '0;
            vel_c         <= '0;
            top_q         <= '0;
            bottom_q      <= '0;
            left_q        <= '0;
            right_q       <= '0;
            calc_row      <= '0;
            calc_col      <= '0;
            calc_vr       <= '0;
            calc_vc       <= '0;
            calc_bv       <= 1'b0;
            calc_bh       <= 1'b0;
            bounce_v      <= 1'b0;
            bounce_h      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            running  <= 1'b1;
            bounce_v <= 1'b0;
            bounce_h <= 1'b0;
            if (frame_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_tick) state <= FETCH;
                    if (cmd_fire) begin
                        case (cmd.cmd_op)
                            OP_SET_VEL: begin
                                vel_r <= clamp_coord(cmd_row, VEL_MIN, VEL_MAX);
                                vel_c <= clamp_coord(cmd_col, VEL_MIN, VEL_MAX);
                            end
                            OP_SET_POS: begin
                                row_offset    <= clamp_coord(cmd_row, ROW_MIN, ROW_MAX);
                                column_offset <= clamp_coord(cmd_col, COL_MIN, COL_MAX);
                            end
                            OP_PAUSE:  paused <= 1'b1;
                            OP_RESUME: paused <= 1'b0;
                            default:   paused <= paused;
                        endcase
                    end
                end
                FETCH: begin
                    top_q    <= pixel_pos[POS_TOP_LSB    +: COORD_W];
                    bottom_q <= pixel_pos[POS_BOTTOM_LSB +: COORD_W];
                    left_q   <= pixel_pos[POS_LEFT_LSB   +: COORD_W];
                    right_q  <= pixel_pos[POS_RIGHT_LSB  +: COORD_W];
                    state    <= CALC;
                end
                CALC: begin
                    calc_row <= nxt_row;
                    calc_col <= nxt_col;
                    calc_vr  <= nxt_vr;
                    calc_vc  <= nxt_vc;
                    calc_bv  <= nxt_bv;
                    calc_bh  <= nxt_bh;
                    state    <= UPDATE;
                end
                UPDATE: begin
                    if (!paused) begin
                        row_offset    <= calc_row;
                        column_offset <= calc_col;
                        vel_r         <= calc_vr;
                        vel_c         <= calc_vc;
                        bounce_v      <= calc_bv;
                        bounce_h      <= calc_bh;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: directed vector table, corner sequences, random vs model.
module tb_sprite_motion_ctrl;
    import sprite_pkg::*;

    localparam int VV = 480;
    localparam int HV = 640;
    localparam int R0 = 100;
    localparam int C0 = 100;
    localparam int MS = 7;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [43:0] pixel_pos;
    coord_t      row_offset, column_offset;
    logic        bounce_v, bounce_h, overrun;

    sprite_motion_ctrl_if cmd_if ();

    sprite_motion_ctrl #(
        .V_VISIBLE   (VV),
        .H_VISIBLE   (HV),
        .SPRITE_ROW0 (R0),
        .SPRITE_COL0 (C0),
        .MAX_SPEED   (MS)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .frame_tick    (frame_tick),
        .cmd           (cmd_if),
        .pixel_pos     (pixel_pos),
        .row_offset    (row_offset),
        .column_offset (column_offset),
        .bounce_v      (bounce_v),
        .bounce_h      (bounce_h),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // 2x2 sprite ROM: edges follow the offsets
    coord_t rom_top, rom_left;
    assign rom_top   = coord_t'(R0) + row_offset;
    assign rom_left  = coord_t'(C0) + column_offset;
    assign pixel_pos = {rom_left + coord_t'(1), rom_left, rom_top + coord_t'(1), rom_top};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: sprite top/left must stay within [0, visible-2]
    int m_row, m_col, m_vr, m_vc;
    bit m_paused;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset;
        m_row = 0; m_col = 0; m_vr = 0; m_vc = 0; m_paused = 0;
    endtask

    task automatic model_cmd(input int op, input int r, input int c);
        case (op)
            0: begin m_vr = clampi(r, -MS, MS); m_vc = clampi(c, -MS, MS); end
            1: begin m_row = clampi(r, -R0, VV - 2 - R0); m_col = clampi(c, -C0, HV - 2 - C0); end
            2: m_paused = 1;
            default: m_paused = 0;
        endcase
    endtask

    task automatic model_axis(input int off, input int vel, input int base, input int vis,
                              output int noff, output int nvel, output bit b);
        int new_top;
        new_top = base + off + vel;
        noff = off + vel; nvel = vel; b = 0;
        if (vel != 0 && (new_top < 0 || new_top > vis - 2)) begin
            b = 1; nvel = -vel;
            noff = (new_top < 0) ? -base : vis - 2 - base;
        end
    endtask

    task automatic model_tick(output bit bv, output bit bh);
        int nr, nc, nvr, nvc;
        bv = 0; bh = 0;
        if (!m_paused) begin
            model_axis(m_row, m_vr, R0, VV, nr, nvr, bv);
            model_axis(m_col, m_vc, C0, HV, nc, nvc, bh);
            m_row = nr; m_vr = nvr; m_col = nc; m_vc = nvc;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        n_reset = 1'b0; frame_tick = 1'b0; cmd_if.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        model_reset();
    endtask

    task automatic send_cmd(input int op, input int r, input int c);
        int waited;
        waited = 0;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = cmd_op_t'(op[1:0]);
        cmd_if.cmd_data  = {11'(r), 11'(c)};
        #1;
        while (!cmd_if.cmd_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check("cmd_ready_wait", int'(waited < 20), 1);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        model_cmd(op, r, c);
    endtask

    // pulse a tick, then stop just after the edge where new offsets land
    task automatic tick_wait;
        @(negedge clk); frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_update(input string tag, input int erow, input int ecol,
                                input bit ebv, input bit ebh);
        check({tag, "_row"}, row_offset, erow);
        check({tag, "_col"}, column_offset, ecol);
        check({tag, "_bv"}, bounce_v, ebv);
        check({tag, "_bh"}, bounce_h, ebh);
        @(posedge clk); #1;
        check({tag, "_bv_end"}, bounce_v, 0);
        check({tag, "_bh_end"}, bounce_h, 0);
    endtask

    typedef struct {
        bit has_cmd; int op; int r; int c; bit tick;
        int e_row; int e_col; bit e_bv; bit e_bh;
    } vec_t;

    vec_t vecs[18];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ebv, ebh;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_SET_VEL;
        cmd_if.cmd_data  = '0;

        vecs[0]  = '{1, 0, 3, -2, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 3, -2, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 6, -4, 0, 0};
        vecs[3]  = '{1, 1, 377, 0, 0, 377, 0, 0, 0};
        vecs[4]  = '{1, 0, 2, 0, 1, 378, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 1, 376, 0, 0, 0};
        vecs[6]  = '{1, 1, 0, -99, 0, 0, -99, 0, 0};
        vecs[7]  = '{1, 0, 0, -5, 1, 0, -100, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 1, 0, -95, 0, 0};
        vecs[9]  = '{1, 0, 20, -20, 1, 7, -100, 0, 1};
        vecs[10] = '{1, 1, 1000, -1000, 0, 378, -100, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 1, 378, -93, 1, 0};
        vecs[12] = '{1, 1, -500, 600, 0, -100, 538, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 1, -100, 538, 1, 1};
        vecs[14] = '{1, 2, 0, 0, 1, -100, 538, 0, 0};
        vecs[15] = '{1, 3, 0, 0, 1, -93, 531, 0, 0};
        vecs[16] = '{1, 1, -100, 538, 0, -100, 538, 0, 0};
        vecs[17] = '{1, 0, 0, 0, 1, -100, 538, 0, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_low", cmd_if.cmd_ready, 0);
        check("rst_row", row_offset, 0);
        check("rst_col", column_offset, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk); n_reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("idle_ready", cmd_if.cmd_ready, 1);
        check("idle_overrun", overrun, 0);
        check("idle_bv", bounce_v, 0);
        check("idle_bh", bounce_h, 0);

        // directed vector table
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].has_cmd) send_cmd(vecs[i].op, vecs[i].r, vecs[i].c);
            if (vecs[i].tick) begin
                tick_wait();
                check_update($sformatf("vec%0d", i), vecs[i].e_row, vecs[i].e_col,
                             vecs[i].e_bv, vecs[i].e_bh);
            end else begin
                check($sformatf("vec%0d_row", i), row_offset, vecs[i].e_row);
                check($sformatf("vec%0d_col", i), column_offset, vecs[i].e_col);
            end
        end
        check("table_no_overrun", overrun, 0);

        // tick and command together, plus a second tick during FETCH
        do_reset();
        @(negedge clk);
        frame_tick = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_SET_VEL;
        cmd_if.cmd_data  = {11'(1), 11'(-1)};
        #1;
        check("collide_ready_low", cmd_if.cmd_ready, 0);
        @(posedge clk); #1;
        check("fetch_ready_low", cmd_if.cmd_ready, 0);
        check("fetch_overrun_clear", overrun, 0);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("overrun_set", overrun, 1);
        check("calc_ready_low", cmd_if.cmd_ready, 0);
        @(posedge clk); #1;
        check("update_ready_low", cmd_if.cmd_ready, 0);
        @(posedge clk); #1;
        check("post_update_ready", cmd_if.cmd_ready, 1);
        check("post_update_row", row_offset, 0);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        model_cmd(0, 1, -1);
        tick_wait();
        model_tick(ebv, ebh);
        check_update("pending_cmd", m_row, m_col, ebv, ebh);
        check("overrun_sticky", overrun, 1);
        do_reset();
        @(posedge clk); #1;
        check("overrun_cleared", overrun, 0);

        // reset during CALC of a bouncing update
        send_cmd(1, 377, 0);
        send_cmd(0, 2, 0);
        @(negedge clk); frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        @(posedge clk); #1;
        n_reset = 1'b0;
        @(posedge clk); #1;
        check("abort_row", row_offset, 0);
        check("abort_bv", bounce_v, 0);
        @(posedge clk); #1;
        check("abort_row2", row_offset, 0);
        check("abort_bv2", bounce_v, 0);
        n_reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("abort_bv3", bounce_v, 0);
        check("abort_col", column_offset, 0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 120; n++) begin
            int k;
            k = int'($urandom_range(0, 5));
            if (k <= 2) begin
                tick_wait();
                model_tick(ebv, ebh);
                check_update($sformatf("rnd%0d", n), m_row, m_col, ebv, ebh);
            end else if (k == 3) begin
                send_cmd(0, int'($urandom_range(0, 24)) - 12, int'($urandom_range(0, 24)) - 12);
            end else if (k == 4) begin
                send_cmd(1, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
            end else begin
                send_cmd(int'($urandom_range(2, 3)), int'($urandom_range(0, 2047)) - 1024, 0);
            end
        end
        check("rnd_overrun", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame position sequencer for the 2x2 square sprite ROM. It drives the ROM's signed 11-bit row_offset/column_offset and reads back its packed pixel_pos edge coordinates. Once per frame tick it advances the sprite by a signed velocity and bounces it off the visible-area edges. Software/game logic sets velocity, position and pause state through a valid/ready command port.

Parameters:
V_VISIBLE, 480, visible rows; legal row coordinates are 0..V_VISIBLE-1.
H_VISIBLE, 640, visible columns; legal column coordinates are 0..H_VISIBLE-1.
SPRITE_ROW0, 100, unshifted top-row coordinate of the sprite in the ROM.
SPRITE_COL0, 100, unshifted left-column coordinate of the sprite in the ROM.
MAX_SPEED, 7, maximum absolute velocity in pixels per frame.

Ports:
clk  in  1  pixel clock; the block's only clock.
n_reset  in  1  synchronous, active-low reset.
frame_tick  in  1  one-cycle pulse at start of vertical blanking.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted on the cycle where valid and ready are both high.
cmd_op  in  2  0=SET_VEL, 1=SET_POS, 2=PAUSE, 3=RESUME.
cmd_data  in  22  {row_val[21:11], col_val[10:0]}, each a signed 11-bit value.
pixel_pos  in  44  from the ROM: {right[43:33], left[32:22], bottom[21:11], top[10:0]}, each signed 11-bit.
row_offset  out  11  signed row offset to the ROM.
column_offset  out  11  signed column offset to the ROM.
bounce_v  out  1  one-cycle pulse when the row velocity is reflected.
bounce_h  out  1  one-cycle pulse when the column velocity is reflected.
overrun  out  1  sticky flag: a frame_tick arrived while an update was in progress.

Behaviour:
- Reset (n_reset=0 at a clk edge):
  - row_offset, column_offset, vel_r, vel_c all 0; paused=0.
  - bounce_v=0, bounce_h=0, overrun=0, cmd_ready=0; state=IDLE.
  - Reset asserted mid-update aborts the update: no partial offset write, no bounce pulse.
- FSM states:
  - IDLE -> FETCH on frame_tick.
  - FETCH: register top, bottom, left, right from pixel_pos.
  - CALC: form candidate positions and bounce decisions.
  - UPDATE: write offsets and velocities, pulse bounce flags, return to IDLE.
- Latency: with a tick sampled at edge T, new offsets are visible after edge T+3, and the bounce pulse is high for the cycle following edge T+3.
- cmd_ready is 1 only in IDLE with frame_tick=0. A simultaneous tick and command gives the tick priority; the command stays pending until ready returns.
- A frame_tick outside IDLE is ignored and sets overrun; overrun is cleared only by reset.
- Paused: the sequence still runs, but the offsets and velocities are left unchanged.
- Arithmetic: 12-bit signed intermediates, results truncated to 11 bits only after clamping.
- Row motion:
  - cand_top = top + vel_r.
  - If cand_top < 0: row_offset = -SPRITE_ROW0, vel_r = -vel_r, bounce_v pulses.
  - Else if cand_bottom = bottom + vel_r > V_VISIBLE-1: row_offset = V_VISIBLE-2-SPRITE_ROW0, vel_r = -vel_r, bounce_v pulses.
  - Else: row_offset += vel_r.
- Column motion uses the same rules with H_VISIBLE and SPRITE_COL0, pulsing bounce_h. Row and column are evaluated independently; both may bounce in the same update.
- SET_VEL: each component is saturated to ±MAX_SPEED. It takes effect from the next tick.
- SET_POS: row_val is clamped to [-SPRITE_ROW0, V_VISIBLE-2-SPRITE_ROW0] and col_val to [-SPRITE_COL0, H_VISIBLE-2-SPRITE_COL0]. Offsets are written on the edge after acceptance.
- PAUSE/RESUME: set or clear paused; cmd_data is ignored.
- Zero velocity never bounces.

Decomposition:
- Package sprite_pkg holds:
  - typedef coord_t (logic signed [10:0]);
  - enum cmd_op_t;
  - enum state_t {IDLE, FETCH, CALC, UPDATE};
  - pixel_pos field slice constants.
- One natural sub-module, axis_step: a combinational helper taking lo/hi edge, velocity, offset, limit and base, and returning the next offset, next velocity and bounce. It is instantiated twice, once per axis.

Test Plan:
- Reset, then idle -> offsets 0/0, cmd_ready=1, overrun=0.
- SET_VEL(+3,-2), tick -> row_offset=3 and column_offset=-2 three cycles after the tick; after a second tick, 6 and -4.
- SET_POS(377,0), SET_VEL(+2,0), tick -> row_offset=378, vel_r=-2, one-cycle bounce_v pulse; next tick -> 376.
- SET_POS(0,-99), SET_VEL(0,-5), tick -> column_offset=-100, bounce_h pulse; next tick -> -95.
- SET_VEL(+20,-20) -> velocities saturate to +7/-7. Tick and cmd_valid in the same cycle -> cmd_ready=0 and the command is accepted right after UPDATE. A second tick during FETCH -> overrun=1.
- PAUSE, tick -> offsets unchanged. Reset asserted during CALC -> offsets 0, no bounce pulse.
